// File: rtl/hdr_ddr_pkg.sv
// Shared types for the HDR-DDR target engine: serializer/deserializer mode
// encodings, engine state encoding and error-code values.
package hdr_ddr_pkg;

  typedef enum logic [2:0] {
    TxPreZero  = 3'd0,
    TxPreOne   = 3'd1,
    TxSerByte  = 3'd2,
    TxParValue = 3'd3,
    TxCrcToken = 3'd4,
    TxCrcValue = 3'd5
  } tx_mode_e;

  typedef enum logic [3:0] {
    RxPreamble  = 4'd0,
    RxDeserData = 4'd1,
    RxCheckPar  = 4'd2,
    RxTokenCrc  = 4'd3,
    RxCrcValue  = 4'd4
  } rx_mode_e;

  typedef enum logic [3:0] {
    StIdle,
    StCmdPre,
    StAck,
    StTurn,
    StByte,
    StParity,
    StDataPre,
    StAbort,
    StCrcPre0,
    StCrcPre1,
    StCrcToken,
    StCrcValue
  } state_e;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrFraming = 2'd1;
  localparam logic [1:0] ErrParity  = 2'd2;
  localparam logic [1:0] ErrOverrun = 2'd3;

endpackage

// File: rtl/hdr_ddr_target_engine_addr_gen.sv
// hdr_tgt_addr_gen: offset / byte index / word counters of the target engine.
// Macro HDR_TGT_WRAP_EN: when defined the window offset wraps to 0 (pulsing
// o_addr_wrap); otherwise offset may reach WINDOW_DEPTH, which flags o_overrun.
// Ports:
//   i_sys_clk, i_sys_rst  clock, async active-high reset
//   i_clear               zero all counters (transaction start)
//   i_byte_adv            one byte transferred
//   i_word_adv            one word (parity) completed
//   o_byte_last           byte index is the last byte of the word
//   o_overrun             next byte access would fall outside the window
//   o_addr_wrap           offset wraps on this byte advance
//   o_word_cnt            completed words
//   o_regf_addr           BASE_ADDR + offset
module hdr_tgt_addr_gen #(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned BASE_ADDR      = 200,
  parameter int unsigned WINDOW_DEPTH   = 64
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_clear,
  input  logic              i_byte_adv,
  input  logic              i_word_adv,
  output logic              o_byte_last,
  output logic              o_overrun,
  output logic              o_addr_wrap,
  output logic [7:0]        o_word_cnt,
  output logic [ADDR_W-1:0] o_regf_addr
);

  // One spare code so the non-wrapping build can represent offset == WINDOW_DEPTH.
  localparam int unsigned OffW = $clog2(WINDOW_DEPTH + 1);

  logic [OffW-1:0] offset_q, offset_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      word_cnt_q, word_cnt_d;

  assign o_byte_last = (byte_idx_q == 2'(BYTES_PER_WORD - 1));

`ifdef HDR_TGT_WRAP_EN
  logic at_top;
  assign at_top      = (offset_q == OffW'(WINDOW_DEPTH - 1));
  assign o_addr_wrap = i_byte_adv & at_top;
  assign o_overrun   = 1'b0;
`else
  assign o_addr_wrap = 1'b0;
  assign o_overrun   = (offset_q == OffW'(WINDOW_DEPTH));
`endif

  always_comb begin
    offset_d   = offset_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    if (i_clear) begin
      offset_d   = '0;
      byte_idx_d = '0;
      word_cnt_d = '0;
    end else begin
      if (i_byte_adv) begin
        byte_idx_d = o_byte_last ? 2'd0 : byte_idx_q + 2'd1;
`ifdef HDR_TGT_WRAP_EN
        offset_d   = at_top ? '0 : offset_q + OffW'(1);
`else
        offset_d   = offset_q + OffW'(1);
`endif
      end
      if (i_word_adv) begin
        word_cnt_d = word_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      offset_q   <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      offset_q   <= offset_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_word_cnt  = word_cnt_q;
  assign o_regf_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(offset_q);

endmodule

// File: rtl/hdr_ddr_target_engine.sv
// hdr_ddr_target_engine: target-side HDR-DDR normal-transaction sequencer.
// Walks command preamble, ACK, N-byte words with parity, data preamble/abort
// and the CRC tail, steering serializer/deserializer modes, bit/frame
// counters and the register-file port. Macro HDR_TGT_WRAP_EN selects window
// wrap (defined) versus overrun termination (undefined).
// Ports:
//   i_sys_clk, i_sys_rst            clock, async active-high reset
//   i_engine_en                     start request (sampled in idle)
//   i_tx_mode_done/i_rx_mode_done   current tx/rx mode finished
//   i_rx_pre, i_rx_error            received preamble bit, parity/CRC error
//   i_rx_ddrccc_rnw                 1 = read (target transmits)
//   i_frmcnt_last                   frame counter at last word
//   o_tx_en/o_rx_en, o_tx_mode/o_rx_mode   serdes control
//   o_engine_done, o_err_code       end pulse, held error code
//   o_sdahand_pp_od                 push-pull select (always 1)
//   o_frmcnt_*, o_bitcnt_*          counter control
//   o_regf_wr_en/o_regf_rd_en/o_regf_addr  register-file port
//   o_word_cnt, o_addr_wrap         word progress, window wrap pulse
module hdr_ddr_target_engine
  import hdr_ddr_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned BASE_ADDR      = 200,
  parameter int unsigned WINDOW_DEPTH   = 64,
  parameter int unsigned MAX_WORDS      = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_engine_en,
  input  logic              i_tx_mode_done,
  input  logic              i_rx_mode_done,
  input  logic              i_rx_pre,
  input  logic              i_rx_error,
  input  logic              i_rx_ddrccc_rnw,
  input  logic              i_frmcnt_last,
  output logic              o_tx_en,
  output logic              o_rx_en,
  output logic [2:0]        o_tx_mode,
  output logic [3:0]        o_rx_mode,
  output logic              o_engine_done,
  output logic [1:0]        o_err_code,
  output logic              o_sdahand_pp_od,
  output logic              o_frmcnt_en,
  output logic              o_frmcnt_rnw,
  output logic              o_bitcnt_en,
  output logic              o_bitcnt_reset,
  output logic              o_regf_wr_en,
  output logic              o_regf_rd_en,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic [7:0]        o_word_cnt,
  output logic              o_addr_wrap
);

  state_e      state_q, state_d;
  logic [1:0]  err_q, err_d;
  tx_mode_e    tx_mode;
  rx_mode_e    rx_mode;
  logic        mode_done, rnw;
  logic        start, byte_adv, word_adv;
  logic        byte_last, overrun;
  logic [7:0]  word_cnt_nxt;
  logic [ADDR_W-1:0] win_addr;

  assign mode_done    = i_tx_mode_done | i_rx_mode_done;
  assign rnw          = i_rx_ddrccc_rnw;
  assign word_cnt_nxt = o_word_cnt + 8'd1;

  hdr_tgt_addr_gen #(
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .WINDOW_DEPTH  (WINDOW_DEPTH)
  ) u_addr_gen (
    .i_sys_clk  (i_sys_clk),
    .i_sys_rst  (i_sys_rst),
    .i_clear    (start),
    .i_byte_adv (byte_adv),
    .i_word_adv (word_adv),
    .o_byte_last(byte_last),
    .o_overrun  (overrun),
    .o_addr_wrap(o_addr_wrap),
    .o_word_cnt (o_word_cnt),
    .o_regf_addr(win_addr)
  );

  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    o_engine_done  = 1'b0;
    start          = 1'b0;
    byte_adv       = 1'b0;
    word_adv       = 1'b0;
    o_tx_en        = 1'b0;
    o_rx_en        = 1'b0;
    tx_mode        = TxPreZero;
    rx_mode        = RxPreamble;
    o_bitcnt_en    = 1'b0;
    o_bitcnt_reset = 1'b0;
    o_frmcnt_en    = 1'b0;
    o_regf_wr_en   = 1'b0;
    o_regf_rd_en   = 1'b0;
    // Counters run in every active state except the turnaround and CRC_PRE0.
    if (state_q != StIdle && state_q != StTurn && state_q != StCrcPre0) begin
      o_bitcnt_en = 1'b1;
      o_frmcnt_en = 1'b1;
    end
    case (state_q)
      StIdle: begin
        o_bitcnt_reset = 1'b1;
        o_rx_en        = i_engine_en;
        if (i_engine_en) begin
          start   = 1'b1;
          err_d   = ErrNone;
          state_d = StCmdPre;
        end
      end
      StCmdPre: begin
        o_rx_en = 1'b1;
        if (mode_done) begin
          if (!i_rx_pre) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrFraming;
          end else begin
            o_tx_en = 1'b1;  // drive ACK from the very cycle the preamble lands
            state_d = StAck;
          end
        end
      end
      StAck: begin
        o_tx_en = 1'b1;
        if (mode_done) state_d = rnw ? StByte : StTurn;
      end
      StTurn: state_d = StByte;
      StByte: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxSerByte;
        end else begin
          o_rx_en = 1'b1;
          rx_mode = RxDeserData;
        end
        if (overrun) begin
          // Access would leave the window: end without touching the regfile.
          state_d       = StIdle;
          o_engine_done = 1'b1;
          err_d         = ErrOverrun;
        end else begin
          o_regf_rd_en = rnw;
          o_regf_wr_en = !rnw;
          if (mode_done) begin
            byte_adv = 1'b1;
            if (byte_last) state_d = StParity;
          end
        end
      end
      StParity: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxParValue;
        end else begin
          o_rx_en = 1'b1;
          rx_mode = RxCheckPar;
        end
        if (mode_done) begin
          word_adv = 1'b1;
          if (!rnw && i_rx_error) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrParity;
          end else if (rnw && (i_frmcnt_last || word_cnt_nxt == 8'(MAX_WORDS))) begin
            state_d = StCrcPre0;
          end else begin
            state_d = StDataPre;
          end
        end
      end
      StDataPre: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxPreOne;
        end else begin
          o_rx_en = 1'b1;
        end
        if (mode_done) begin
          if (rnw) begin
            state_d = StAbort;
          end else if (!i_rx_pre) begin
            state_d = StCrcPre1;
          end else if (o_word_cnt == 8'(MAX_WORDS)) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrOverrun;
          end else begin
            state_d = StByte;
          end
        end
      end
      StAbort: begin
        o_rx_en = 1'b1;
        if (mode_done) begin
          if (!i_rx_pre) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrNone;
          end else begin
            state_d = StByte;
          end
        end
      end
      StCrcPre0: begin
        o_tx_en        = 1'b1;
        o_bitcnt_reset = 1'b1;
        if (mode_done) state_d = StCrcPre1;
      end
      StCrcPre1: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxPreOne;
        end else begin
          o_rx_en = 1'b1;
        end
        if (mode_done) begin
          if (!rnw && !i_rx_pre) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrFraming;
          end else begin
            state_d = StCrcToken;
          end
        end
      end
      StCrcToken: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxCrcToken;
        end else begin
          o_rx_en = 1'b1;
          rx_mode = RxTokenCrc;
        end
        if (mode_done) begin
          if (!rnw && i_rx_error) begin
            state_d       = StIdle;
            o_engine_done = 1'b1;
            err_d         = ErrParity;
          end else begin
            state_d = StCrcValue;
          end
        end
      end
      StCrcValue: begin
        if (rnw) begin
          o_tx_en = 1'b1;
          tx_mode = TxCrcValue;
        end else begin
          o_rx_en = 1'b1;
          rx_mode = RxCrcValue;
        end
        if (mode_done) begin
          state_d       = StIdle;
          o_engine_done = 1'b1;
          if (!rnw && i_rx_error) err_d = ErrParity;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= StIdle;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign o_tx_mode       = tx_mode;
  assign o_rx_mode       = rx_mode;
  assign o_err_code      = err_q;
  assign o_sdahand_pp_od = 1'b1;
  assign o_frmcnt_rnw    = rnw;
  assign o_regf_addr     = (state_q == StIdle) ? ADDR_W'(BASE_ADDR) : win_addr;

endmodule

// File: doc/hdr_ddr_target_engine.md
Name: hdr_ddr_target_engine

Overview:
Parametrised target-side HDR-DDR normal-transaction engine, the successor to the fixed two-byte target FSM. It sequences command preamble, ACK, an N-byte data word, parity, data preamble/abort and the CRC tail. It drives the serializer/deserializer modes, the bit/frame counters and the register-file port. It adds configurable bytes-per-word, a register window with wrap, a burst word limit and an error code. It sits between the HDR engine top and the tx/rx/regfile blocks.

Parameters:
BYTES_PER_WORD, 2, data bytes per DDR word (1..4)
ADDR_W, 10, register-file address width
BASE_ADDR, 200, first regfile address of the window
WINDOW_DEPTH, 64, bytes in the window (power of two not required)
MAX_WORDS, 16, maximum data words per transaction (1..255)

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  asynchronous, active-high reset
i_engine_en  in  1  start a transaction (sampled in IDLE)
i_tx_mode_done / i_rx_mode_done  in  1 each  current tx/rx mode finished
i_rx_pre  in  1  received preamble bit value
i_rx_error  in  1  rx parity/CRC mismatch
i_rx_ddrccc_rnw  in  1  1 = read (target transmits)
i_frmcnt_last  in  1  frame counter reached last word
o_tx_en, o_rx_en  out  1 each  enable serializer / deserializer
o_tx_mode  out  3  tx mode (package enum)
o_rx_mode  out  4  rx mode (package enum)
o_engine_done  out  1  one-cycle transaction-end pulse
o_err_code  out  2  0 none, 1 framing, 2 parity/CRC, 3 overrun; held until next start
o_sdahand_pp_od  out  1  always 1 (push-pull)
o_frmcnt_en, o_frmcnt_rnw  out  1 each  frame counter enable; rnw = i_rx_ddrccc_rnw
o_bitcnt_en, o_bitcnt_reset  out  1 each  bit counter control
o_regf_wr_en, o_regf_rd_en  out  1 each  regfile strobes
o_regf_addr  out  ADDR_W  BASE_ADDR + offset
o_word_cnt  out  8  words completed in current transaction
o_addr_wrap  out  1  one-cycle pulse when offset wraps

Behaviour:
- mode_done = i_tx_mode_done | i_rx_mode_done. Outputs are combinational from state plus qualifiers. Counters and o_err_code are registered.
- Reset: state IDLE, offset 0, byte_idx 0, o_word_cnt 0, o_err_code 0.
- IDLE-state outputs: o_bitcnt_reset=1, o_rx_mode=PREAMBLE, o_tx_mode=PRE_ZERO, o_regf_addr=BASE_ADDR, o_rx_en=i_engine_en; all other outputs 0 except o_sdahand_pp_od=1.
- IDLE: i_engine_en -> CMD_PRE. On this transition, clear offset, byte_idx, word_cnt and err_code.
- CMD_PRE: rx PREAMBLE, bitcnt_en, frmcnt_en.
  - On mode_done with i_rx_pre=0: -> IDLE, engine_done, err 1.
  - On mode_done with i_rx_pre=1: -> ACK, tx_en=1 in the same cycle.
- ACK: tx_en, tx PRE_ZERO. On mode_done: read -> BYTE; write -> TURN.
- TURN: exactly one cycle, no enables asserted -> BYTE.
- BYTE: tx SER_BYTE / rx DESER_DATA by direction; regf rd_en (read) or wr_en (write); addr = BASE_ADDR + offset.
  - Each mode_done increments offset and byte_idx.
  - When byte_idx == BYTES_PER_WORD-1: clear byte_idx and go -> PARITY.
- Offset at WINDOW_DEPTH-1 plus one: behaviour set by HDR_TGT_WRAP_EN (see Optional Feature).
- PARITY: tx PAR_VALUE / rx CHECK_PAR. On mode_done, increment word_cnt, then:
  - write with i_rx_error -> IDLE, engine_done, err 2;
  - read with (i_frmcnt_last or new word_cnt == MAX_WORDS) -> CRC_PRE0;
  - otherwise -> DATA_PRE.
- DATA_PRE: rx PREAMBLE on write, tx PRE_ONE on read. On mode_done:
  - write, i_rx_pre=0 -> CRC_PRE1;
  - write, i_rx_pre=1, word_cnt == MAX_WORDS -> IDLE, engine_done, err 3;
  - write, i_rx_pre=1, otherwise -> BYTE;
  - read -> ABORT.
- ABORT: read only; rx PREAMBLE. On mode_done: i_rx_pre=0 -> IDLE, engine_done, err 0 (controller abort); i_rx_pre=1 -> BYTE.
- CRC_PRE0: tx_en, PRE_ZERO, bitcnt_reset, frmcnt_en=0. On mode_done -> CRC_PRE1.
- CRC_PRE1: tx PRE_ONE on read; rx on write. On mode_done: write with i_rx_pre=0 -> IDLE, engine_done, err 1; otherwise -> CRC_TOKEN.
- CRC_TOKEN: tx CRC_TOKEN / rx TOKEN_CRC. On mode_done: write with i_rx_error -> IDLE, done, err 2; otherwise -> CRC_VALUE.
- CRC_VALUE: on mode_done -> IDLE, engine_done; err 2 if write with i_rx_error.
- Simultaneous mode_done and i_rx_error: error wins.
- Reset mid-transaction: immediate return to IDLE with reset values; no done pulse.
- Latency: the done pulse coincides with the final mode_done cycle.

Optional Feature:
- Macro: HDR_TGT_WRAP_EN.
- Defined: offset wraps from WINDOW_DEPTH-1 to 0, o_addr_wrap pulses for one cycle, and the transfer continues.
- Undefined: the byte access that would exceed the window instead ends the transaction: -> IDLE, engine_done, err 3, strobes suppressed that cycle. o_addr_wrap is tied to 0.

Decomposition:
- Package hdr_ddr_pkg holds the tx mode enum, the rx mode enum, the state enum and the error-code constants.
- Sub-module hdr_tgt_addr_gen: offset/byte_idx/word_cnt counters, wrap or overrun detect, o_regf_addr adder.

Test Plan:
- Write, 2 words, BYTES_PER_WORD=2, good parity/CRC -> wr_en at addr 200..203, word_cnt=2, one done pulse, err 0.
- CMD_PRE with i_rx_pre=0 -> IDLE next cycle, done, err 1, no regfile strobe.
- Read, i_frmcnt_last on word 3 -> CRC_PRE0 after 3rd PARITY, rd addrs 200..205, done at CRC_VALUE, err 0.
- Read, controller drives 0 in ABORT after word 1 -> done, err 0, word_cnt=1.
- Write with WINDOW_DEPTH=4, 3 words:
  - HDR_TGT_WRAP_EN defined: addr 200,201,202,203,200,201 and one o_addr_wrap pulse.
  - HDR_TGT_WRAP_EN undefined: err 3 at the 5th byte.
- Write parity error on word 1 -> done, err 2. Reset asserted mid-BYTE -> IDLE immediately, counters 0.
